// File: rtl/differential_transmitter_if.sv
// Symbol handshake between a source and the differential transmitter.
interface differential_transmitter_if #(
  parameter int unsigned WIDTH = 10
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  // Source side: presents symbols and holds them until accepted.
  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  // Transmitter side.
  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/differential_transmitter.sv
// Parallel-to-serial D+/D- line driver. Symbols are shifted out LSB first, one bit per clock.
// D+ carries the inverted bit, D- the bit itself; both lines float in electrical idle.
module differential_transmitter #(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  differential_transmitter_if.slave  tx,
  input  logic                       elec_idle_req,
  output wire                        d_p,
  output wire                        d_n,
  output logic                       elec_idle_out,
  output logic                       busy
);

  localparam int unsigned CntW  = $clog2(WIDTH);
  localparam int unsigned WakeW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  localparam logic [CntW-1:0]  CntLast  = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]  CntPen   = CntW'(WIDTH - 2);
  localparam logic [WakeW-1:0] WakeLast = WakeW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    StEidle,
    StWake,
    StL0,
    StShift
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WakeW-1:0] wake_q, wake_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             line_q, line_d;
  logic             ready_q, ready_d;
  logic             accept;

  // ready_q is registered, so a handshake completes on the edge where both are high.
  assign accept = tx.valid_in & ready_q;

  // Next-state, shift datapath and registered ready.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wake_d  = wake_q;
    shift_d = shift_q;
    line_d  = line_q;
    ready_d = 1'b0;

    case (state_q)
      StEidle: begin
        line_d = 1'b0;
        if (!elec_idle_req) begin
          state_d = StWake;
          wake_d  = '0;
        end
      end

      StWake: begin
        line_d = 1'b0;
        if (elec_idle_req) begin
          state_d = StEidle;
        end else if (wake_q == WakeLast) begin
          state_d = StL0;
          ready_d = 1'b1;
        end else begin
          wake_d = wake_q + 1'b1;
        end
      end

      StL0: begin
        line_d = 1'b0;
        if (accept) begin
          state_d = StShift;
          count_d = '0;
          line_d  = tx.data_in[0];
          shift_d = tx.data_in >> 1;
        end else if (elec_idle_req) begin
          state_d = StEidle;
        end else begin
          ready_d = 1'b1;
        end
      end

      StShift: begin
        if (count_q == CntLast) begin
          if (accept) begin
            // Back-to-back: the next symbol's bit 0 follows the last bit with no gap.
            count_d = '0;
            line_d  = tx.data_in[0];
            shift_d = tx.data_in >> 1;
          end else if (elec_idle_req) begin
            state_d = StEidle;
            line_d  = 1'b0;
          end else begin
            state_d = StL0;
            line_d  = 1'b0;
            ready_d = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
          line_d  = shift_q[0];
          shift_d = shift_q >> 1;
          // Offer the next slot only while the last bit is on the line.
          ready_d = (count_q == CntPen) & ~elec_idle_req;
        end
      end

      default: begin
        state_d = StEidle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEidle;
      count_q <= '0;
      wake_q  <= '0;
      shift_q <= '0;
      line_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wake_q  <= wake_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      ready_q <= ready_d;
    end
  end

  assign tx.ready_out  = ready_q;
  assign elec_idle_out = (state_q == StEidle);
  assign busy          = (state_q == StShift);

  // Both lines float together; when driven, D- is the bit and D+ its complement.
  assign d_p = elec_idle_out ? 1'bz : ~line_q;
  assign d_n = elec_idle_out ? 1'bz : line_q;

endmodule

// File: tb/tb_differential_transmitter.sv
// Directed bench for the differential transmitter: idle, wake, single, back-to-back,
// mid-symbol idle request and mid-symbol reset.
module tb_differential_transmitter;

  localparam int unsigned WIDTH       = 10;
  localparam int unsigned WAKE_CYCLES = 4;

  logic clk = 1'b0;
  logic rst;
  logic elec_idle_req;
  wire  d_p;
  wire  d_n;
  logic elec_idle_out;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  differential_transmitter_if #(.WIDTH(WIDTH)) tx_if ();

  differential_transmitter #(
    .WIDTH      (WIDTH),
    .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx           (tx_if.slave),
    .elec_idle_req(elec_idle_req),
    .d_p          (d_p),
    .d_n          (d_n),
    .elec_idle_out(elec_idle_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for a negedge with ready_out high; the next posedge accepts.
  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_if.ready_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    logic [4:0] exp;
    rst = 1'b1;
    elec_idle_req = 1'b1;
    tx_if.valid_in = 1'b1;
    tx_if.data_in = 10'h3FF;
    repeat (2) @(negedge clk);
    // {d_p, d_n, busy, ready_out, elec_idle_out}
    exp = {1'bz, 1'bz, 1'b0, 1'b0, 1'b1};
    got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=%b", got, exp);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL eidle_hold cycle=%0d got=%b want=%b", i, got, exp);
      end
    end
    tx_if.valid_in = 1'b0;
  endtask

  task automatic test_wake();
    int wake_cnt;
    logic seen_ready;
    logic [2:0] got;
    wake_cnt = 0;
    seen_ready = 1'b0;
    elec_idle_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_if.ready_out === 1'b1) begin
        seen_ready = 1'b1;
        break;
      end
      if ({d_p, d_n, elec_idle_out} === 3'b100) wake_cnt++;
    end
    n_checks++;
    if (seen_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wake_timeout got=%b want=1", seen_ready);
    end
    n_checks++;
    if (wake_cnt != WAKE_CYCLES) begin
      n_fail++;
      $display("FAIL wake_count got=%0d want=%0d", wake_cnt, WAKE_CYCLES);
    end
    got = {d_p, d_n, busy};
    n_checks++;
    if (got !== 3'b100) begin
      n_fail++;
      $display("FAIL l0_lines got=%b want=100", got);
    end
  endtask

  task automatic test_single();
    logic ok;
    logic [WIDTH-1:0] w;
    logic b;
    logic [4:0] got;
    logic [4:0] exp;
    w = 10'h2A5;
    wait_ready(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready_timeout got=%b want=1", ok);
    end
    tx_if.data_in = w;
    tx_if.valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) tx_if.valid_in = 1'b0;
      b = w[i];
      exp = {~b, b, 1'b1, (i == 9) ? 1'b1 : 1'b0, 1'b0};
      got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single_bit%0d got=%b want=%b", i, got, exp);
      end
    end
    @(negedge clk);
    got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
    n_checks++;
    if (got !== 5'b10010) begin
      n_fail++;
      $display("FAIL single_back_to_l0 got=%b want=10010", got);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic [2*WIDTH-1:0] w;
    logic b;
    logic [4:0] got;
    logic [4:0] exp;
    w = {10'h0FF, 10'h2A5};
    wait_ready(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_timeout got=%b want=1", ok);
    end
    tx_if.data_in = 10'h2A5;
    tx_if.valid_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      b = w[i];
      exp = {~b, b, 1'b1, (i == 9 || i == 19) ? 1'b1 : 1'b0, 1'b0};
      got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b_bit%0d got=%b want=%b", i, got, exp);
      end
      if (i == 0) tx_if.data_in = 10'h0FF;
      if (i == 10) tx_if.valid_in = 1'b0;
    end
    @(negedge clk);
    got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
    n_checks++;
    if (got !== 5'b10010) begin
      n_fail++;
      $display("FAIL b2b_back_to_l0 got=%b want=10010", got);
    end
  endtask

  task automatic test_idle_mid_symbol();
    logic ok;
    logic [WIDTH-1:0] w;
    logic b;
    logic [4:0] got;
    logic [4:0] exp;
    w = 10'h3C0;
    wait_ready(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready_timeout got=%b want=1", ok);
    end
    tx_if.data_in = w;
    tx_if.valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b = w[i];
      exp = {~b, b, 1'b1, 1'b0, 1'b0};
      got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL idle_mid_bit%0d got=%b want=%b", i, got, exp);
      end
      if (i == 0) tx_if.valid_in = 1'b0;
      if (i == 3) elec_idle_req = 1'b1;
    end
    @(negedge clk);
    exp = {1'bz, 1'bz, 1'b0, 1'b0, 1'b1};
    got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL idle_after_symbol got=%b want=%b", got, exp);
    end
  endtask

  task automatic test_reset_mid_symbol();
    logic ok;
    logic [WIDTH-1:0] w;
    logic b;
    logic [4:0] got;
    logic [4:0] exp;
    elec_idle_req = 1'b0;
    w = 10'h0F0;
    wait_ready(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready_timeout got=%b want=1", ok);
    end
    tx_if.data_in = w;
    tx_if.valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b = w[i];
      exp = {~b, b, 1'b1, 1'b0, 1'b0};
      got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rst_pre_bit%0d got=%b want=%b", i, got, exp);
      end
      if (i == 0) tx_if.valid_in = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    exp = {1'bz, 1'bz, 1'b0, 1'b0, 1'b1};
    got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL rst_mid_symbol got=%b want=%b", got, exp);
    end
    rst = 1'b0;
    w = 10'h155;
    wait_ready(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_ready_timeout got=%b want=1", ok);
    end
    tx_if.data_in = w;
    tx_if.valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) tx_if.valid_in = 1'b0;
      b = w[i];
      exp = {~b, b, 1'b1, (i == 9) ? 1'b1 : 1'b0, 1'b0};
      got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL restart_bit%0d got=%b want=%b", i, got, exp);
      end
    end
    @(negedge clk);
    got = {d_p, d_n, busy, tx_if.ready_out, elec_idle_out};
    n_checks++;
    if (got !== 5'b10010) begin
      n_fail++;
      $display("FAIL restart_back_to_l0 got=%b want=10010", got);
    end
  endtask

  initial begin
    rst = 1'b1;
    elec_idle_req = 1'b1;
    tx_if.valid_in = 1'b0;
    tx_if.data_in = '0;
    test_reset();
    test_wake();
    test_single();
    test_back_to_back();
    test_idle_mid_symbol();
    test_reset_mid_symbol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
